// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths and arbiter state encoding
package bus_pkg;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = 4;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/bus_arbiter_2_rr_pick.sv
// rr_pick_2: two-way winner select, round-robin against last_grant or fixed port-0 priority
module rr_pick_2 (
  input  logic [1:0] pend_i,
  input  logic       last_grant_i,
  input  logic       rr_en_i,
  output logic       winner_o,
  output logic       any_o
);
  assign any_o    = |pend_i;
  assign winner_o = (&pend_i) ? (rr_en_i & ~last_grant_i) : pend_i[1];
endmodule

// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: shares one bus host port between two requesters with grant hold and timeout
module bus_arbiter_2
  import bus_pkg::*;
#(
  parameter bit          RR_ENABLE      = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*BUS_ADDR_W-1:0] req_address,
  input  logic [2*BUS_DATA_W-1:0] req_data_write,
  input  logic [2*BUS_MASK_W-1:0] req_write_mask,
  input  logic [1:0]              req_ren,
  input  logic [1:0]              req_wen,
  output logic [2*BUS_DATA_W-1:0] req_data_read,
  output logic [1:0]              req_ready,
  output logic [BUS_ADDR_W-1:0]   bus_address,
  output logic [BUS_DATA_W-1:0]   bus_data_write,
  output logic [BUS_MASK_W-1:0]   bus_write_mask,
  output logic                    bus_ren,
  output logic                    bus_wen,
  input  logic [BUS_DATA_W-1:0]   bus_data_read,
  input  logic                    bus_ready,
  output logic                    timeout_err,
  output logic                    timeout_port
);
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;
  arb_state_t state_q, state_d;
  logic grant_q, grant_d, last_grant_q, last_grant_d, tport_q, tport_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0] pend;
  logic busy, pend_g, done_ok, to, fin, winner, any;
  logic [BUS_DATA_W-1:0] rd;
  assign pend    = req_ren | req_wen;
  assign busy    = state_q == ARB_BUSY;
  assign pend_g  = pend[grant_q];
  assign done_ok = busy & pend_g & bus_ready;
  assign to      = busy & pend_g & ~bus_ready & (TIMEOUT_CYCLES != 0) & (tcnt_q == T_LAST);
  assign fin     = done_ok | to;
  // While busy, arbitrate against the current grant so a regrant picks the other port first
  rr_pick_2 u_pick (
    .pend_i      (pend),
    .last_grant_i(busy ? grant_q : last_grant_q),
    .rr_en_i     (RR_ENABLE),
    .winner_o    (winner),
    .any_o       (any)
  );
  // State register: FSM, grant history, timeout counter and last timeout port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
      tport_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
      tport_q      <= tport_d;
    end
  end
  // Next state: grant on request, regrant without gap on completion, drop on abandon
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tcnt_d       = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + TW'(1);
    tport_d      = to ? grant_q : tport_q;
    if (!busy) begin
      tcnt_d  = '0;
      state_d = any ? ARB_BUSY : ARB_IDLE;
      grant_d = any ? winner : grant_q;
    end else if (fin) begin
      last_grant_d = grant_q;
      tcnt_d       = '0;
      state_d      = (any && winner != grant_q) ? ARB_BUSY : ARB_IDLE;
      grant_d      = (any && winner != grant_q) ? winner : grant_q;
    end else if (!pend_g) begin
      state_d = ARB_IDLE;
    end
  end
  // Outputs: bus mux of the granted port, completion routed back to that port only
  always_comb begin
    rd             = to ? ERR_DATA : bus_data_read;
    bus_address    = busy ? (grant_q ? req_address[63:32] : req_address[31:0]) : '0;
    bus_data_write = busy ? (grant_q ? req_data_write[63:32] : req_data_write[31:0]) : '0;
    bus_write_mask = busy ? (grant_q ? req_write_mask[7:4] : req_write_mask[3:0]) : '0;
    bus_ren        = busy & req_ren[grant_q] & ~to;
    bus_wen        = busy & req_wen[grant_q] & ~to;
    req_ready      = fin ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    req_data_read  = fin ? (grant_q ? {rd, 32'h0} : {32'h0, rd}) : '0;
    timeout_err    = to;
    timeout_port   = to ? grant_q : tport_q;
  end
endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb_bus_arbiter_2: directed checks of round-robin (with timeout) and fixed-priority arbiters
module tb_bus_arbiter_2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_address, req_data_write;
  logic [7:0]  req_write_mask;
  logic [1:0]  req_ren, req_wen;
  logic [31:0] bus_data_read;
  logic        bus_ready;
  logic [63:0] a_rdata, b_rdata;
  logic [1:0]  a_rdy, b_rdy;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [3:0]  a_mask, b_mask;
  logic        a_ren, a_wen, a_terr, a_tport, b_ren, b_wen, b_terr, b_tport;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  bus_arbiter_2 #(.RR_ENABLE(1'b1), .TIMEOUT_CYCLES(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_address(req_address), .req_data_write(req_data_write),
    .req_write_mask(req_write_mask), .req_ren(req_ren), .req_wen(req_wen),
    .req_data_read(a_rdata), .req_ready(a_rdy), .bus_address(a_addr), .bus_data_write(a_wdata),
    .bus_write_mask(a_mask), .bus_ren(a_ren), .bus_wen(a_wen), .bus_data_read(bus_data_read),
    .bus_ready(bus_ready), .timeout_err(a_terr), .timeout_port(a_tport)
  );
  bus_arbiter_2 #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_address(req_address), .req_data_write(req_data_write),
    .req_write_mask(req_write_mask), .req_ren(req_ren), .req_wen(req_wen),
    .req_data_read(b_rdata), .req_ready(b_rdy), .bus_address(b_addr), .bus_data_write(b_wdata),
    .bus_write_mask(b_mask), .bus_ren(b_ren), .bus_wen(b_wen), .bus_data_read(bus_data_read),
    .bus_ready(bus_ready), .timeout_err(b_terr), .timeout_port(b_tport)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_ren = '0;
    req_wen = '0;
    bus_ready = 1'b0;
    bus_data_read = '0;
    cyc;
    cyc;
    rst_n = 1'b1;
  endtask
  initial begin
    req_address = '0;
    req_data_write = '0;
    req_write_mask = '0;
    do_reset;
    #1;
    chk("rst_ren", a_ren, 0);
    chk("rst_wen", a_wen, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_terr", a_terr, 0);
    chk("rst_tport", a_tport, 0);
    req_address = {32'h0, 32'h100};
    req_ren = 2'b01;
    #1 chk("t1_latency", a_ren, 0);
    cyc; #1;
    chk("t1_addr", a_addr, 32'h100);
    chk("t1_ren", a_ren, 1);
    chk("t1_rdy0", a_rdy, 0);
    cyc;
    cyc;
    bus_ready = 1'b1;
    bus_data_read = 32'h12345678;
    #1;
    chk("t1_rdy", a_rdy, 2'b01);
    chk("t1_rdata", a_rdata, 64'h12345678);
    cyc;
    req_ren = 0;
    bus_ready = 0;
    #1;
    chk("t1_idle_rdy", a_rdy, 0);
    chk("t1_idle_ren", a_ren, 0);
    do_reset;
    req_address = {32'h300, 32'h200};
    req_data_write = {32'hBBBB, 32'hAAAA};
    req_write_mask = 8'hF3;
    req_wen = 2'b11;
    cyc; #1;
    chk("t2_wen0", a_wen, 1);
    chk("t2_addr0", a_addr, 32'h200);
    chk("t2_wdata0", a_wdata, 32'hAAAA);
    chk("t2_mask0", a_mask, 4'h3);
    bus_ready = 1'b1;
    #1 chk("t2_rdy0", a_rdy, 2'b01);
    cyc;
    req_wen = 2'b10;
    bus_ready = 1'b0;
    #1;
    chk("t2_addr1", a_addr, 32'h300);
    chk("t2_wen1", a_wen, 1);
    chk("t2_mask1", a_mask, 4'hF);
    chk("t2_norder", a_rdy, 0);
    bus_ready = 1'b1;
    #1 chk("t2_rdy1", a_rdy, 2'b10);
    cyc;
    req_wen = 0;
    bus_ready = 0;
    #1 chk("t2_idle", a_wen, 0);
    do_reset;
    req_ren = 2'b11;
    bus_ready = 1'b1;
    bus_data_read = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      chk("t2_alt", a_rdy, i[0] ? 2'b10 : 2'b01);
    end
    do_reset;
    req_ren = 2'b11;
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      chk("t3_fixed", b_rdy, i[0] ? 2'b00 : 2'b01);
    end
    req_ren = 2'b10;
    cyc; #1;
    chk("t3_p1_rdy", b_rdy, 2'b10);
    chk("t3_p1_addr", b_addr, 32'h300);
    do_reset;
    req_address = {32'h400, 32'h0};
    req_ren = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc; #1;
      chk("t4_wait_rdy", a_rdy, 0);
      chk("t4_wait_ren", a_ren, 1);
    end
    cyc; #1;
    chk("t4_to_rdy", a_rdy, 2'b10);
    chk("t4_to_data", a_rdata, 64'hDEADBEEF_00000000);
    chk("t4_to_err", a_terr, 1);
    chk("t4_to_port", a_tport, 1);
    chk("t4_to_ren", a_ren, 0);
    cyc;
    req_ren = 0;
    #1;
    chk("t4_err_clr", a_terr, 0);
    chk("t4_port_hold", a_tport, 1);
    req_ren = 2'b10;
    for (int i = 0; i < 3; i++) cyc;
    cyc;
    bus_ready = 1'b1;
    bus_data_read = 32'hCAFE0001;
    #1;
    chk("t4_race_rdy", a_rdy, 2'b10);
    chk("t4_race_data", a_rdata, 64'hCAFE0001_00000000);
    chk("t4_race_err", a_terr, 0);
    do_reset;
    req_address = {32'h500, 32'h50};
    req_ren = 2'b01;
    cyc; #1;
    chk("t5_busy", a_ren, 1);
    cyc;
    req_ren = 2'b10;
    #1 chk("t5_abandon", a_rdy, 0);
    cyc; #1;
    chk("t5_idle_ren", a_ren, 0);
    chk("t5_idle_rdy", a_rdy, 0);
    cyc; #1;
    chk("t5_p1_addr", a_addr, 32'h500);
    chk("t5_p1_ren", a_ren, 1);
    do_reset;
    req_address = {32'h600, 32'h60};
    req_ren = 2'b10;
    cyc; #1;
    chk("t6_busy_addr", a_addr, 32'h600);
    rst_n = 1'b0;
    req_ren = 2'b11;
    cyc; #1;
    chk("t6_rst_ren", a_ren, 0);
    chk("t6_rst_rdy", a_rdy, 0);
    rst_n = 1'b1;
    cyc; #1;
    chk("t6_first_addr", a_addr, 32'h60);
    chk("t6_first_ren", a_ren, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
